shift_serializer: RTL
=====================

Name: shift_serializer

Overview:
Parallel-in / serial-out controller that sequences a bank of Size stages of Width bits.
- Accepts one parallel word of Width*Size bits through a valid/ready handshake.
- Emits the word as Size consecutive Width-bit symbols through a second valid/ready handshake, with first/last framing flags.
- Sits between a word-wide producer and a narrow serial consumer, such as a link or pin interface. Supports back-to-back frames with no idle cycle.

Parameters:
- Width, 1: bits per serial symbol.
- Size, 4: symbols per word; legal range 2..256.
- MsbFirst, 0: 0 emits the least-significant symbol first; 1 emits the most-significant symbol first.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  parallel word valid.
- in_ready_o  out  1  controller can accept a parallel word this cycle.
- in_data_i  in  Width*Size  parallel word; symbol k is bits [k*Width +: Width].
- out_valid_o  out  1  serial symbol valid.
- out_ready_i  in  1  consumer accepts the symbol this cycle.
- out_data_o  out  Width  current serial symbol.
- out_first_o  out  1  current symbol is symbol index 0 of the frame.
- out_last_o  out  1  current symbol is the final symbol of the frame.
- busy_o  out  1  a frame is in progress.

Behaviour:
- Handshakes: input transfer = in_valid_i && in_ready_o; output transfer = out_valid_o && out_ready_i. Both are sampled on the rising clock edge.
- State: FSM {IDLE, SHIFT}, plus:
  - a holding register hold[Width*Size-1:0];
  - a symbol counter cnt of width max(1,$clog2(Size)).
- Reset (rst_ni low, asynchronous): state=IDLE, cnt=0, hold=0. Therefore out_valid_o=0, out_first_o=0, out_last_o=0, busy_o=0, out_data_o=0, and in_ready_o=1 once reset is released. Reset mid-frame discards the frame and emits no further symbols.
- IDLE:
  - in_ready_o=1, out_valid_o=0.
  - On an input transfer: hold<=in_data_i, cnt<=0, go to SHIFT. The first symbol is valid the next cycle, so latency from input transfer to out_valid_o is 1 cycle.
- SHIFT:
  - out_valid_o=1, busy_o=1.
  - out_data_o = hold[Width-1:0] when MsbFirst=0; hold[Width*Size-1 -: Width] when MsbFirst=1.
  - out_first_o = (cnt==0); out_last_o = (cnt==Size-1).
  - Output transfer when not last: cnt<=cnt+1; hold shifts by Width toward the output end, zero-filled.
  - No output transfer (out_ready_i=0): hold, cnt and all outputs remain stable. out_data_o must not change while out_valid_o=1 and out_ready_i=0.
  - in_ready_o = out_last_o && out_ready_i. This is a combinational path from out_ready_i and is permitted.
  - Output transfer on the last symbol:
    - If in_valid_i=1 (simultaneous input transfer): hold<=in_data_i, cnt<=0, stay in SHIFT. The next cycle presents symbol 0 of the new frame with no bubble.
    - Else: go to IDLE.
- in_data_i is ignored whenever in_ready_o=0. in_valid_i held high during a frame does not corrupt hold.
- Throughput: Size symbols per Size cycles when out_ready_i is held at 1 and a new word is always available.
- cnt never exceeds Size-1; no wrap-around path exists.
- Outputs are registered-derived (from state, cnt, hold), except in_ready_o as stated above.

Test Plan:
- Width=4, Size=4, MsbFirst=0; reset, then in_data_i=16'hA5C3 with in_valid_i pulsed for 1 cycle, out_ready_i=1 -> out_data_o = 3, C, 5, A on 4 consecutive cycles starting 1 cycle after the transfer. out_first_o high on 3 only; out_last_o high on A only; then out_valid_o=0 and in_ready_o=1.
- Same word with MsbFirst=1 -> out_data_o = A, 5, C, 3.
- Back-to-back: words 16'h1234 then 16'h5678 with in_valid_i held at 1, out_ready_i=1 -> 8 contiguous valid cycles: 4,3,2,1,8,7,6,5. in_ready_o is high only on the cycles presenting symbol 1 and symbol 5.
- Backpressure: word 16'hA5C3, out_ready_i=0 for 3 cycles while symbol C (cnt=1) is presented -> out_data_o stays C, out_first_o=0, out_last_o=0, in_ready_o=0. Serialization resumes with 5 when out_ready_i returns to 1.
- Input ignored: in_data_i=16'hFFFF with in_valid_i=1 during the middle of a frame while out_ready_i=0 -> the frame continues unchanged, and 16'hFFFF is accepted only on the cycle the last symbol transfers.
- Reset mid-frame: assert rst_ni=0 asynchronously (between clock edges) while presenting symbol index 2 -> out_valid_o, busy_o and out_data_o go to 0 immediately. After release, in_ready_o=1 and no stale symbols are emitted.

Source files
------------

// File: rtl/shift_serializer.sv
// shift_serializer: parallel-in / serial-out word sequencer.
// Loads one Width*Size word, then emits Size framed Width-bit symbols.
module shift_serializer #(
   parameter int Width    = 1,
   parameter int Size     = 4,
   parameter bit MsbFirst = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [Width*Size-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [Width-1:0]      out_data_o,
   output logic                  out_first_o,
   output logic                  out_last_o,
   output logic                  busy_o
);

   localparam int TotalW = Width * Size;
   localparam int CntW   = (Size > 2) ? $clog2(Size) : 1;

   localparam logic [CntW-1:0] LastCnt = CntW'(Size - 1);
   localparam logic [CntW-1:0] OneCnt  = CntW'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   state_e              state_q;
   state_e              state_d;
   logic [CntW-1:0]     cnt_q;
   logic [CntW-1:0]     cnt_d;
   logic [TotalW-1:0]   hold_q;
   logic [TotalW-1:0]   hold_d;
   logic [TotalW-1:0]   hold_next;
   logic [Width-1:0]    head_sym;
   logic                shifting;
   logic                is_first;
   logic                is_last;
   logic                in_xfer;
   logic                out_xfer;

   assign shifting = (state_q == SHIFT);
   assign is_first = shifting && (cnt_q == '0);
   assign is_last  = shifting && (cnt_q == LastCnt);

   // The output end of hold depends on symbol order; refill is zero.
   generate
      if (MsbFirst) begin : g_msb
         assign head_sym  = hold_q[TotalW-1 -: Width];
         assign hold_next = hold_q << Width;
      end else begin : g_lsb
         assign head_sym  = hold_q[Width-1:0];
         assign hold_next = hold_q >> Width;
      end
   endgenerate

   // A new word is taken when idle, or as the last symbol leaves.
   assign in_ready_o  = shifting ? (is_last && out_ready_i) : 1'b1;
   assign in_xfer     = in_valid_i && in_ready_o;
   assign out_xfer    = out_valid_o && out_ready_i;

   assign out_valid_o = shifting;
   assign busy_o      = shifting;
   assign out_first_o = is_first;
   assign out_last_o  = is_last;
   assign out_data_o  = shifting ? head_sym : '0;

   // Next-state, counter and holding-register update.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (in_xfer) begin
               hold_d  = in_data_i;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (out_xfer) begin
               if (is_last) begin
                  if (in_xfer) begin
                     hold_d = in_data_i;
                     cnt_d  = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  hold_d = hold_next;
                  cnt_d  = cnt_q + OneCnt;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset drops any frame in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

endmodule
